// File: rtl/gpio_comm_responder_pkg.sv
// gpio_comm_pkg: shared states and constants for the GPIO byte-serial link endpoint
package gpio_comm_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int TURN_TOGGLE = 0;
  localparam int TURN_FLAG = 1;
  typedef enum logic [2:0] {RX_IDLE, RX_CAP, RX_REQ, RX_WAIT, RX_FIN} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_PUT, TX_TOG, TX_ACK} tx_state_t;
endpackage

// File: rtl/gpio_comm_responder_if.sv
// gpio_comm_responder_if: word-wide valid/ready side toward the core
interface gpio_comm_responder_if;
  logic [31:0] rx_data_o;
  logic rx_valid_o;
  logic rx_ready_i;
  logic [31:0] tx_data_i;
  logic tx_valid_i;
  logic tx_ready_o;
  modport slave(output rx_data_o, rx_valid_o, tx_ready_o, input rx_ready_i, tx_data_i, tx_valid_i);
  modport master(input rx_data_o, rx_valid_o, tx_ready_o, output rx_ready_i, tx_data_i, tx_valid_i);
endinterface

// File: rtl/gpio_comm_responder_sync.sv
// gpio_comm_sync: N-bit multi-flop synchronizer for bridge-driven inputs
module gpio_comm_sync #(
  parameter int N = 1,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  logic [STAGES-1:0][N-1:0] ff;
  always_ff @(posedge clk or negedge reset_ni)
    if (!reset_ni) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/gpio_comm_responder.sv
// gpio_comm_responder: receives/transmits 32-bit words over the 8-bit GPIO toggle-handshake link
module gpio_comm_responder
  import gpio_comm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic [7:0] gpio_data_in,
  input  logic [1:0] data_in_io_turn,
  output logic [1:0] data_in_pulpino_turn,
  input  logic data_out_io_turn,
  output logic [1:0] data_out_pulpino_turn,
  output logic [7:0] gpio_data_out,
  gpio_comm_responder_if.slave bus
);
  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  logic [7:0] s_data;
  logic [1:0] s_in_io;
  logic s_out_io;
  logic [1:0] rx_idx, tx_idx;
  logic last_io0, last_out_io;
  logic [31:0] rx_shift, tx_shift;

  // data and turn lines share one chain so a byte and its toggle arrive together
  gpio_comm_sync #(.N(11), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset_ni(reset_ni),
    .d({data_out_io_turn, data_in_io_turn, gpio_data_in}),
    .q({s_out_io, s_in_io, s_data})
  );

  assign bus.tx_ready_o = (tx_state == TX_IDLE);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (s_in_io[TURN_FLAG] && !bus.rx_valid_o) rx_next = RX_CAP;
      RX_CAP:  rx_next = (rx_idx == LAST) ? RX_FIN : RX_REQ;
      RX_REQ:  rx_next = RX_WAIT;
      RX_WAIT: if (s_in_io[TURN_TOGGLE] != last_io0) rx_next = RX_CAP;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni)
    if (!reset_ni) begin
      rx_state <= RX_IDLE;
      rx_idx <= '0;
      last_io0 <= 1'b0;
      rx_shift <= '0;
      bus.rx_data_o <= '0;
      bus.rx_valid_o <= 1'b0;
      data_in_pulpino_turn <= '0;
    end else begin
      rx_state <= rx_next;
      if (bus.rx_valid_o && bus.rx_ready_i) bus.rx_valid_o <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_next == RX_CAP) begin
          last_io0 <= s_in_io[TURN_TOGGLE];
          rx_idx <= '0;
        end
        RX_CAP:  rx_shift[8*rx_idx+:8] <= s_data;
        RX_REQ:  data_in_pulpino_turn <= {1'b0, ~data_in_pulpino_turn[TURN_TOGGLE]};
        RX_WAIT: if (rx_next == RX_CAP) begin
          last_io0 <= s_in_io[TURN_TOGGLE];
          rx_idx <= rx_idx + 2'd1;
        end
        RX_FIN: begin
          data_in_pulpino_turn <= {1'b1, ~data_in_pulpino_turn[TURN_TOGGLE]};
          bus.rx_data_o <= rx_shift;
          bus.rx_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (bus.tx_valid_i) tx_next = TX_PUT;
      TX_PUT:  tx_next = TX_TOG;
      TX_TOG:  tx_next = TX_ACK;
      default: if (s_out_io != last_out_io) tx_next = (tx_idx == LAST) ? TX_IDLE : TX_PUT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni)
    if (!reset_ni) begin
      tx_state <= TX_IDLE;
      tx_idx <= '0;
      last_out_io <= 1'b0;
      tx_shift <= '0;
      gpio_data_out <= '0;
      data_out_pulpino_turn <= '0;
    end else begin
      tx_state <= tx_next;
      case (tx_state)
        TX_IDLE: if (bus.tx_valid_i) begin
          tx_shift <= bus.tx_data_i;
          tx_idx <= '0;
          last_out_io <= s_out_io;
        end
        TX_PUT: gpio_data_out <= tx_shift[8*tx_idx+:8];
        TX_TOG: data_out_pulpino_turn <= {tx_idx == LAST, ~data_out_pulpino_turn[TURN_TOGGLE]};
        default: if (s_out_io != last_out_io) begin
          last_out_io <= s_out_io;
          if (tx_idx != LAST) tx_idx <= tx_idx + 2'd1;
        end
      endcase
    end
endmodule

// File: tb/tb_gpio_comm_responder.sv
// tb_gpio_comm_responder: directed bench with bridge-side models for both link directions
module tb_gpio_comm_responder;
  logic clk = 1'b0;
  logic reset_ni;
  logic [7:0] gpio_data_in;
  logic [1:0] data_in_io_turn;
  logic [1:0] data_in_pulpino_turn;
  logic data_out_io_turn;
  logic [1:0] data_out_pulpino_turn;
  logic [7:0] gpio_data_out;
  int total = 0;
  int bad = 0;
  logic [31:0] got;
  logic [1:0] snap_in, snap_out;
  logic prev5;
  int t5;

  gpio_comm_responder_if bus();

  gpio_comm_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset_ni(reset_ni),
    .gpio_data_in(gpio_data_in),
    .data_in_io_turn(data_in_io_turn),
    .data_in_pulpino_turn(data_in_pulpino_turn),
    .data_out_io_turn(data_out_io_turn),
    .data_out_pulpino_turn(data_out_pulpino_turn),
    .gpio_data_out(gpio_data_out),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // host side of the bridge: loads a word and shifts it in on each request
  task automatic bridge_rx(input logic [31:0] w, input int maxd, input bit glitch);
    logic prev;
    int shifts, dones, b, t;
    shifts = 0; dones = 0; b = 1; t = 0;
    @(negedge clk);
    gpio_data_in = w[7:0];
    data_in_io_turn[1] = 1'b1;
    prev = data_in_pulpino_turn[0];
    while (dones == 0 && t < 400) begin
      @(negedge clk);
      t++;
      if (data_in_pulpino_turn[0] != prev) begin
        prev = data_in_pulpino_turn[0];
        if (data_in_pulpino_turn[1]) begin
          dones++;
          check("rx_valid_at_done", {31'b0, bus.rx_valid_o}, 32'd1);
        end else begin
          shifts++;
          if (glitch) begin
            gpio_data_in = 8'hEE;
            repeat (6) @(negedge clk);
          end
          repeat ($urandom_range(maxd, 0)) @(negedge clk);
          gpio_data_in = w[8*(b&3)+:8];
          data_in_io_turn = {1'b0, ~data_in_io_turn[0]};
          b++;
        end
      end
    end
    check("rx_shifts", shifts, 32'd3);
    check("rx_dones", dones, 32'd1);
  endtask

  // receiving side of the bridge: collects bytes and acks each toggle
  task automatic bridge_tx(output logic [31:0] w, input int maxd);
    logic prev;
    int b, t;
    w = '0; b = 0; t = 0;
    prev = data_out_pulpino_turn[0];
    while (b < 4 && t < 400) begin
      @(negedge clk);
      t++;
      if (data_out_pulpino_turn[0] != prev) begin
        prev = data_out_pulpino_turn[0];
        w[8*b+:8] = gpio_data_out;
        check("tx_last_flag", {31'b0, data_out_pulpino_turn[1]}, {31'b0, b == 3});
        repeat ($urandom_range(maxd, 0)) @(negedge clk);
        check("tx_byte_stable", {24'b0, gpio_data_out}, {24'b0, w[8*b+:8]});
        data_out_io_turn = ~data_out_io_turn;
        b++;
      end
    end
    check("tx_byte_count", b, 32'd4);
  endtask

  task automatic send_tx(input logic [31:0] w);
    int t = 0;
    @(negedge clk);
    bus.tx_data_i = w;
    bus.tx_valid_i = 1'b1;
    while (!bus.tx_ready_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("tx_accept", {31'b0, bus.tx_ready_o}, 32'd1);
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    check("tx_busy", {31'b0, bus.tx_ready_o}, 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_in_turn", {30'b0, data_in_pulpino_turn}, 32'd0);
    check("rst_out_turn", {30'b0, data_out_pulpino_turn}, 32'd0);
    check("rst_gpio_out", {24'b0, gpio_data_out}, 32'd0);
    check("rst_rx_data", bus.rx_data_o, 32'd0);
    check("rst_rx_valid", {31'b0, bus.rx_valid_o}, 32'd0);
    check("rst_tx_ready", {31'b0, bus.tx_ready_o}, 32'd1);
  endtask

  initial begin
    reset_ni = 1'b0;
    gpio_data_in = 8'h00;
    data_in_io_turn = 2'b00;
    data_out_io_turn = 1'b0;
    bus.rx_ready_i = 1'b0;
    bus.tx_data_i = '0;
    bus.tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset_ni = 1'b1;
    repeat (3) @(negedge clk);

    bridge_rx(32'hDEADBEEF, 0, 1'b0);
    check("rx_word1", bus.rx_data_o, 32'hDEADBEEF);
    check("rx_valid1", {31'b0, bus.rx_valid_o}, 32'd1);

    // second word must wait until the held first word is drained
    snap_in = data_in_pulpino_turn;
    fork
      bridge_rx(32'hCAFEF00D, 0, 1'b0);
      begin
        repeat (30) @(negedge clk);
        check("hold_no_toggle", {30'b0, data_in_pulpino_turn}, {30'b0, snap_in});
        check("hold_data", bus.rx_data_o, 32'hDEADBEEF);
        bus.rx_ready_i = 1'b1;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
      end
    join
    check("rx_word2", bus.rx_data_o, 32'hCAFEF00D);
    bus.rx_ready_i = 1'b1;
    @(negedge clk);
    check("rx_drain", {31'b0, bus.rx_valid_o}, 32'd0);

    fork
      send_tx(32'h12345678);
      bridge_tx(got, 0);
    join
    check("tx_word1", got, 32'h12345678);
    repeat (4) @(negedge clk);
    check("tx_ready_back", {31'b0, bus.tx_ready_o}, 32'd1);

    fork
      bridge_rx(32'h01020304, 7, 1'b0);
      send_tx(32'hA5A55A5A);
      bridge_tx(got, 7);
    join
    check("conc_rx", bus.rx_data_o, 32'h01020304);
    check("conc_tx", got, 32'hA5A55A5A);
    snap_in = data_in_pulpino_turn;
    snap_out = data_out_pulpino_turn;
    repeat (20) @(negedge clk);
    check("no_extra_in", {30'b0, data_in_pulpino_turn}, {30'b0, snap_in});
    check("no_extra_out", {30'b0, data_out_pulpino_turn}, {30'b0, snap_out});

    bridge_rx(32'h11223344, 2, 1'b1);
    check("rx_glitch_word", bus.rx_data_o, 32'h11223344);

    // reset after the first outbound byte has been acked
    prev5 = data_out_pulpino_turn[0];
    t5 = 0;
    fork
      send_tx(32'h87654321);
      begin
        while (data_out_pulpino_turn[0] == prev5 && t5 < 400) begin
          @(negedge clk);
          t5++;
        end
        check("mid_first_toggle", {31'b0, data_out_pulpino_turn[0]}, {31'b0, ~prev5});
        data_out_io_turn = ~data_out_io_turn;
        repeat (4) @(negedge clk);
      end
    join
    reset_ni = 1'b0;
    #1;
    check_reset_values();
    data_out_io_turn = 1'b0;
    data_in_io_turn = 2'b00;
    @(negedge clk);
    reset_ni = 1'b1;
    repeat (4) @(negedge clk);
    fork
      send_tx(32'h00000001);
      bridge_tx(got, 3);
    join
    check("tx_after_reset", got, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
